// File: rtl/blit_sequencer.sv
// blit_sequencer: emits PXCOPY/PXPASTE command pairs for a W x H rectangle copy with back-pressure.
// Optional BLIT_REVERSE_EN enables bottom-right-first scanning when the destination follows the source.
module blit_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] src_x,
  input  logic [11:0] src_y,
  input  logic [11:0] dst_x,
  input  logic [11:0] dst_y,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic        use_mask,
  input  logic [7:0]  transp_colour,
  input  logic        abort,
  input  logic        pix_adr_busy,
  output logic        draw_cmd_rdy,
  output logic [35:0] draw_cmd,
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0, COPY = 2'd1, PASTE = 2'd2, FIN = 2'd3;
  logic [1:0]  state;
  logic [11:0] sx, sy, dx, dy, w, h, cx, cy, ox, oy;
  logic [7:0]  tc;
  logic        m, rev, last_col, last_row;
  assign draw_cmd_rdy = (state == COPY || state == PASTE) && !abort && !pix_adr_busy;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign last_col = cx == w - 12'd1;
  assign last_row = cy == h - 12'd1;
  // Reverse mode mirrors the counters so the scan starts at the bottom-right pixel.
  assign ox = rev ? w - 12'd1 - cx : cx;
  assign oy = rev ? h - 12'd1 - cy : cy;
  assign draw_cmd = state == COPY  ? {4'd6, tc, sy + oy, sx + ox} :
                    state == PASTE ? {m ? 4'd4 : 4'd3, tc, dy + oy, dx + ox} : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      {sx, sy, dx, dy, w, h, cx, cy} <= '0;
      tc <= '0;
      m <= 1'b0;
      rev <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        {sx, sy, dx, dy, w, h} <= {src_x, src_y, dst_x, dst_y, width, height};
        tc <= transp_colour;
        m <= use_mask;
        cx <= '0;
        cy <= '0;
`ifdef BLIT_REVERSE_EN
        rev <= dst_y > src_y || (dst_y == src_y && dst_x > src_x);
`else
        rev <= 1'b0;
`endif
        state <= (width == 12'd0 || height == 12'd0) ? FIN : COPY;
      end
    end else if (abort || state == FIN) begin
      state <= IDLE;
    end else if (draw_cmd_rdy) begin
      if (state == COPY) state <= PASTE;
      else if (!last_col) begin
        cx <= cx + 12'd1;
        state <= COPY;
      end else if (!last_row) begin
        cx <= '0;
        cy <= cy + 12'd1;
        state <= COPY;
      end else state <= FIN;
    end
endmodule
